// File: rtl/aes_round_controller.sv
// Round sequencer for the iterative AES core. It drives the load select, the per-round
// datapath enables and the round number, then flags done while the core holds the cipher text.
`timescale 1ns/1ps
module aes_round_controller #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter bit          WAIT_ACK   = 1'b0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic       ack,
    output logic       busy,
    output logic       done,
    output logic       accept,
    output logic [3:0] rndNo,
    output logic       enbSB,
    output logic       enbSR,
    output logic       enbMC,
    output logic       enbAR,
    output logic       enbKS
);
    localparam int unsigned    RcW         = 4;
    localparam logic [RcW-1:0] LastFullRnd = RcW'(NUM_ROUNDS - 1);
    localparam logic [RcW-1:0] FinalRnd    = RcW'(NUM_ROUNDS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } stateT;

    stateT          stateQ, stateD;
    logic [RcW-1:0] rcQ, rcD;

    logic           busyD, doneD, acceptD;
    logic [RcW-1:0] rndNoD;
    logic           enbSBD, enbSRD, enbMCD, enbARD, enbKSD;

    // State, round counter and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stateQ <= IDLE;
            rcQ    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            accept <= 1'b0;
            rndNo  <= '0;
            enbSB  <= 1'b0;
            enbSR  <= 1'b0;
            enbMC  <= 1'b0;
            enbAR  <= 1'b0;
            enbKS  <= 1'b0;
        end else begin
            stateQ <= stateD;
            rcQ    <= rcD;
            busy   <= busyD;
            done   <= doneD;
            accept <= acceptD;
            rndNo  <= rndNoD;
            enbSB  <= enbSBD;
            enbSR  <= enbSRD;
            enbMC  <= enbMCD;
            enbAR  <= enbARD;
            enbKS  <= enbKSD;
        end
    end

    // Next state/counter, then decode the outputs of the state being entered so the
    // registered outputs always equal the Moore decode of the state/counter registers.
    always_comb begin
        stateD  = stateQ;
        rcD     = rcQ;
        busyD   = 1'b0;
        doneD   = 1'b0;
        acceptD = 1'b0;
        rndNoD  = '0;
        enbSBD  = 1'b0;
        enbSRD  = 1'b0;
        enbMCD  = 1'b0;
        enbARD  = 1'b0;
        enbKSD  = 1'b0;

        case (stateQ)
            IDLE: begin
                if (start) begin
                    stateD = LOAD;
                    rcD    = '0;
                end
            end
            LOAD: begin
                stateD = ROUND;
                rcD    = RcW'(1);
            end
            ROUND: begin
                if (rcQ >= LastFullRnd) begin
                    stateD = FINAL;
                    rcD    = FinalRnd;
                end else begin
                    rcD = rcQ + RcW'(1);
                end
            end
            FINAL: begin
                stateD = DONE;
                rcD    = '0;
            end
            DONE: begin
                // start is deliberately not looked at here; a new op must be requested in IDLE
                if (!WAIT_ACK || ack) begin
                    stateD = IDLE;
                end
            end
            default: begin
                stateD = IDLE;
                rcD    = '0;
            end
        endcase

        case (stateD)
            LOAD: begin
                busyD   = 1'b1;
                acceptD = 1'b1;
                enbARD  = 1'b1;
            end
            ROUND: begin
                busyD  = 1'b1;
                rndNoD = rcD;
                enbSBD = 1'b1;
                enbSRD = 1'b1;
                enbMCD = 1'b1;
                enbARD = 1'b1;
                enbKSD = 1'b1;
            end
            FINAL: begin
                busyD  = 1'b1;
                rndNoD = FinalRnd;
                enbSBD = 1'b1;
                enbSRD = 1'b1;
                enbARD = 1'b1;
                enbKSD = 1'b1;
            end
            DONE: begin
                doneD = 1'b1;
            end
            default: begin
                busyD = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_round_controller.sv
// Bench for aes_round_controller: a behavioural AES-128 core follows the controller's
// enables, and its cipher text is scoreboarded against FIPS-197 vectors on every done.
`timescale 1ns/1ps
module tb_aes_round_controller;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk;
    logic rstn;
    logic start0, ack0, start1, ack1;
    logic busy0, done0, accept0, enbSB0, enbSR0, enbMC0, enbAR0, enbKS0;
    logic busy1, done1, accept1, enbSB1, enbSR1, enbMC1, enbAR1, enbKS1;
    logic [3:0] rndNo0, rndNo1;
    logic [11:0] ctl0, ctl1;
    logic [127:0] pt, key;
    logic [127:0] ct0, rk0, ct1, rk1;
    logic [127:0] q0[$];
    logic [127:0] q1[$];
    logic [127:0] e0, e1;
    logic donePrev0, donePrev1;
    int checks, passes;

    aes_round_controller #(.NUM_ROUNDS(10), .WAIT_ACK(1'b0)) dut0 (
        .clk(clk), .rstn(rstn), .start(start0), .ack(ack0),
        .busy(busy0), .done(done0), .accept(accept0), .rndNo(rndNo0),
        .enbSB(enbSB0), .enbSR(enbSR0), .enbMC(enbMC0), .enbAR(enbAR0), .enbKS(enbKS0)
    );

    aes_round_controller #(.NUM_ROUNDS(10), .WAIT_ACK(1'b1)) dut1 (
        .clk(clk), .rstn(rstn), .start(start1), .ack(ack1),
        .busy(busy1), .done(done1), .accept(accept1), .rndNo(rndNo1),
        .enbSB(enbSB1), .enbSR(enbSR1), .enbMC(enbMC1), .enbAR(enbAR1), .enbKS(enbKS1)
    );

    assign ctl0 = {busy0, done0, accept0, rndNo0, enbSB0, enbSR0, enbMC0, enbAR0, enbKS0};
    assign ctl1 = {busy1, done1, accept1, rndNo1, enbSB1, enbSR1, enbMC1, enbAR1, enbKS1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // S-box from the GF(2^8) inverse (b^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv, sq, r;
        inv = 8'h01; sq = b;
        for (int i = 0; i < 7; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        for (int i = 0; i < 8; i++)
            r[i] = inv[i] ^ inv[3'(i + 4)] ^ inv[3'(i + 5)] ^ inv[3'(i + 6)] ^ inv[3'(i + 7)];
        return r ^ 8'h63;
    endfunction

    function automatic logic [127:0] expandKey(input logic [127:0] rk, input logic [3:0] rnd);
        logic [31:0] w0, w1, w2, w3, tmp;
        logic [7:0] rc;
        w0 = rk[127:96]; w1 = rk[95:64]; w2 = rk[63:32]; w3 = rk[31:0];
        rc = 8'h01;
        for (int i = 1; i < int'(rnd); i++) rc = xt(rc);
        tmp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        w0 = w0 ^ tmp; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // One clock of the iterative core; returns {next state, next round key}
    function automatic logic [255:0] coreStep(input logic [127:0] st, input logic [127:0] rk,
                                              input logic [127:0] p, input logic [127:0] k,
                                              input logic acc, input logic sb, input logic sr,
                                              input logic mc, input logic ar, input logic ks,
                                              input logic [3:0] rnd);
        logic [7:0] s[16];
        logic [7:0] t[16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] nk, ns;
        if (acc) return {(ar ? (p ^ k) : p), k};
        for (int i = 0; i < 16; i++) s[i] = st[127 - 8*i -: 8];
        if (sb) for (int i = 0; i < 16; i++) s[i] = sbox(s[i]);
        if (sr) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) t[4*c + r] = s[4*((c + r) % 4) + r];
            s = t;
        end
        if (mc) begin
            for (int c = 0; c < 4; c++) begin
                a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
            s = t;
        end
        nk = ks ? expandKey(rk, rnd) : rk;
        for (int i = 0; i < 16; i++) ns[127 - 8*i -: 8] = s[i];
        if (ar) ns = ns ^ nk;
        return {ns, nk};
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ct0 <= '0; rk0 <= '0; ct1 <= '0; rk1 <= '0;
        end else begin
            {ct0, rk0} <= coreStep(ct0, rk0, pt, key, accept0, enbSB0, enbSR0, enbMC0, enbAR0, enbKS0, rndNo0);
            {ct1, rk1} <= coreStep(ct1, rk1, pt, key, accept1, enbSB1, enbSR1, enbMC1, enbAR1, enbKS1, rndNo1);
        end
    end

    // Scoreboards: pop one expected cipher text per rising done
    always @(negedge clk) begin
        if (rstn && done0 && !donePrev0) begin
            checks++;
            if (q0.size() == 0) $display("FAIL sb0_unexpected_done: got ct %h, required no done", ct0);
            else begin
                e0 = q0.pop_front();
                if (ct0 !== e0) $display("FAIL sb0_ct: got %h required %h", ct0, e0);
                else passes++;
            end
        end
        if (rstn && done1 && !donePrev1) begin
            checks++;
            if (q1.size() == 0) $display("FAIL sb1_unexpected_done: got ct %h, required no done", ct1);
            else begin
                e1 = q1.pop_front();
                if (ct1 !== e1) $display("FAIL sb1_ct: got %h required %h", ct1, e1);
                else passes++;
            end
        end
        donePrev0 = done0;
        donePrev1 = done1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Control word {busy,done,accept,rndNo,SB,SR,MC,AR,KS} n cycles after the start edge
    function automatic logic [11:0] expCtl(input int n);
        if (n == 0) return {1'b1, 1'b0, 1'b1, 4'd0, 5'b00010};
        if (n >= 1 && n <= 9) return {1'b1, 1'b0, 1'b0, 4'(n), 5'b11111};
        if (n == 10) return {1'b1, 1'b0, 1'b0, 4'd10, 5'b11011};
        if (n == 11) return {1'b0, 1'b1, 1'b0, 4'd0, 5'b00000};
        return 12'h000;
    endfunction

    task automatic test_reset();
        rstn = 1'b1;
        #1 rstn = 1'b0;
        start0 = 1'b1;
        tick(); tick();
        checks++;
        if (ctl0 !== 12'h000) $display("FAIL reset_dut0: got %h required 000", ctl0); else passes++;
        checks++;
        if (ctl1 !== 12'h000) $display("FAIL reset_dut1: got %h required 000", ctl1); else passes++;
        start0 = 1'b0;
        rstn = 1'b1;
        tick();
        checks++;
        if (ctl0 !== 12'h000) $display("FAIL idle_after_reset: got %h required 000", ctl0); else passes++;
    endtask

    task automatic test_fips();
        int n;
        pt = P1; key = K1;
        q0.push_back(C1);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        n = 0;
        while (!done0 && n < 30) begin tick(); n++; end
        checks++;
        if (n != 11) $display("FAIL fips_latency: got %0d cycles required 11", n); else passes++;
        tick();
        checks++;
        if (done0 !== 1'b0) $display("FAIL fips_done_pulse: got done=%b required 0", done0); else passes++;
        repeat (2) tick();
    endtask

    task automatic test_control_trace();
        int busyCnt;
        busyCnt = 0;
        q0.push_back(C1);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int n = 0; n <= 12; n++) begin
            checks++;
            if (ctl0 !== expCtl(n)) $display("FAIL trace_n%0d: got %h required %h", n, ctl0, expCtl(n));
            else passes++;
            busyCnt += int'(busy0);
            tick();
        end
        checks++;
        if (busyCnt != 11) $display("FAIL trace_busy_len: got %0d required 11", busyCnt); else passes++;
    endtask

    task automatic test_mid_op_start();
        int cnt, at;
        cnt = 0; at = -1;
        q0.push_back(C1);
        start0 = 1'b1;
        tick();
        for (int n = 0; n <= 20; n++) begin
            start0 = (n == 3 || n == 9 || n == 11);
            if (done0) begin
                cnt++;
                if (at < 0) at = n;
            end
            tick();
        end
        start0 = 1'b0;
        checks++;
        if (cnt != 1) $display("FAIL midstart_done_count: got %0d required 1", cnt); else passes++;
        checks++;
        if (at != 11) $display("FAIL midstart_done_at: got %0d required 11", at); else passes++;
        checks++;
        if (ctl0 !== 12'h000) $display("FAIL midstart_idle: got %h required 000", ctl0); else passes++;
    endtask

    task automatic test_wait_ack();
        int n;
        pt = P1; key = K1;
        q1.push_back(C1);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 30) begin tick(); n++; end
        checks++;
        if (n != 11) $display("FAIL ack_latency: got %0d required 11", n); else passes++;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({done1, ct1} !== {1'b1, C1}) $display("FAIL ack_hold_%0d: got done=%b ct=%h required done=1 ct=%h", i, done1, ct1, C1);
            else passes++;
        end
        ack1 = 1'b1;
        tick();
        ack1 = 1'b0;
        checks++;
        if (ctl1 !== 12'h000) $display("FAIL ack_release: got %h required 000", ctl1); else passes++;
        // back-to-back, second vector, acked on the first done cycle
        pt = P2; key = K2;
        q1.push_back(C2);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 30) begin tick(); n++; end
        checks++;
        if (n != 11) $display("FAIL b2b_latency_1: got %0d required 11", n); else passes++;
        ack1 = 1'b1;
        tick();
        ack1 = 1'b0;
        checks++;
        if (done1 !== 1'b0) $display("FAIL b2b_release_1: got done=%b required 0", done1); else passes++;
        // ack held through the whole op: ignored until DONE, then done lasts one cycle
        pt = P1; key = K1;
        q1.push_back(C1);
        ack1 = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 30) begin tick(); n++; end
        checks++;
        if (n != 11) $display("FAIL b2b_latency_2: got %0d required 11", n); else passes++;
        tick();
        ack1 = 1'b0;
        checks++;
        if (done1 !== 1'b0) $display("FAIL b2b_release_2: got done=%b required 0", done1); else passes++;
        repeat (2) tick();
    endtask

    task automatic test_async_reset();
        int n;
        pt = P1; key = K1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        n = 0;
        while (rndNo0 != 4'd5 && n < 20) begin tick(); n++; end
        checks++;
        if (n != 5) $display("FAIL areset_reach_rnd5: got %0d cycles required 5", n); else passes++;
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (ctl0 !== 12'h000) $display("FAIL areset_immediate: got %h required 000", ctl0); else passes++;
        tick(); tick();
        rstn = 1'b1;
        tick();
        pt = P2; key = K2;
        q0.push_back(C2);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        n = 0;
        while (!done0 && n < 30) begin tick(); n++; end
        checks++;
        if (n != 11) $display("FAIL areset_fresh_latency: got %0d required 11", n); else passes++;
        repeat (2) tick();
    endtask

    task automatic test_start_held();
        int cnt, busyCnt;
        int at[4];
        cnt = 0; busyCnt = 0;
        for (int i = 0; i < 4; i++) at[i] = -1;
        pt = P1; key = K1;
        for (int i = 0; i < 3; i++) q0.push_back(C1);
        ack0 = 1'b1;
        start0 = 1'b1;
        tick();
        for (int n = 0; n <= 45; n++) begin
            if (done0) begin
                if (cnt < 4) at[cnt] = n;
                cnt++;
            end
            busyCnt += int'(busy0);
            if (n == 26) start0 = 1'b0;
            tick();
        end
        ack0 = 1'b0;
        checks++;
        if (cnt != 3) $display("FAIL held_done_count: got %0d required 3", cnt); else passes++;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (at[i] != 11 + 13*i) $display("FAIL held_done_at_%0d: got %0d required %0d", i, at[i], 11 + 13*i);
            else passes++;
        end
        checks++;
        if (busyCnt != 33) $display("FAIL held_busy_total: got %0d required 33", busyCnt); else passes++;
    endtask

    task automatic test_drain();
        checks++;
        if (q0.size() != 0) $display("FAIL drain_q0: got %0d pending required 0", q0.size()); else passes++;
        checks++;
        if (q1.size() != 0) $display("FAIL drain_q1: got %0d pending required 0", q1.size()); else passes++;
    endtask

    initial begin
        checks = 0; passes = 0;
        start0 = 1'b0; ack0 = 1'b0; start1 = 1'b0; ack1 = 1'b0;
        pt = P1; key = K1;
        donePrev0 = 1'b0; donePrev1 = 1'b0;
        test_reset();
        test_fips();
        test_control_trace();
        test_mid_op_start();
        test_wait_ack();
        test_async_reset();
        test_start_held();
        test_drain();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
